// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the minimum-digit width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Decimal digits needed to show 2^bin_w-1.
    // 30103/100000 approximates log10(2); bin_w*log10(2) is never an
    // integer, so floor()+1 equals the digit count.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/dabble_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is >= 5.
// Ports: din (4-bit digit in), dout (4-bit corrected digit, no carry out).
module dabble_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Ports: clk, reset (sync, active-high), start/ready handshake, bin in,
// done (1-cycle pulse), bcd (packed digits, digit 0 in bcd[3:0]).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                ready,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    if (DIGITS < min_digits(BIN_W)) begin : g_width_err
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BIN_W-1:0]    sreg;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_adj;
    logic [AW+BIN_W-1:0] nxt;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        dabble_digit u_dig (
            .din  (acc[4*d +: 4]),
            .dout (acc_adj[4*d +: 4])
        );
    end

    // Correct digits first, then shift sreg MSB into acc bit 0.
    assign nxt = {acc_adj, sreg} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            bcd   <= '0;
            sreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg  <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc  <= nxt[AW+BIN_W-1:BIN_W];
                    sreg <= nxt[BIN_W-1:0];
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd   <= acc;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: 8-bit and 16-bit instances.
// Expected BCD values are queued at start and checked on done.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, ready8, done8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;
    logic        start16, ready16, done16;
    logic [15:0] bin16;
    logic [19:0] bcd16;

    int n_chk  = 0;
    int n_pass = 0;
    int ndone8 = 0;
    int ndone16 = 0;
    logic done8_q = 1'b0;
    logic done16_q = 1'b0;

    logic [31:0] q8[$];
    logic [31:0] q16[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .bin   (bin8),
        .ready (ready8),
        .done  (done8),
        .bcd   (bcd8)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .bin   (bin16),
        .ready (ready16),
        .done  (done16),
        .bcd   (bcd16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard and done-width monitor
    always @(negedge clk) begin
        if (done8_q)
            chk("done8_width", {31'd0, done8}, 32'd0);
        if (done8) begin
            ndone8++;
            if (q8.size() == 0)
                chk("done8_spurious", {31'd0, done8}, 32'd0);
            else
                chk("bcd8", {20'd0, bcd8}, q8.pop_front());
        end
        done8_q <= done8;
        if (done16_q)
            chk("done16_width", {31'd0, done16}, 32'd0);
        if (done16) begin
            ndone16++;
            if (q16.size() == 0)
                chk("done16_spurious", {31'd0, done16}, 32'd0);
            else
                chk("bcd16", {12'd0, bcd16}, q16.pop_front());
        end
        done16_q <= done16;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go8(input logic [7:0] v, input bit push);
        int t;
        t = 0;
        while (!ready8 && t < 100) begin
            tick();
            t++;
        end
        if (!ready8)
            chk("rdy8_timeout", {31'd0, ready8}, 32'd1);
        start8 = 1'b1;
        bin8   = v;
        if (push)
            q8.push_back(ref_bcd(v));
        tick();
        start8 = 1'b0;
        bin8   = 8'($urandom);
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        tick();
        chk("q8_drain", q8.size(), 0);
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (done8)
                break;
        end
    endtask

    initial begin
        int lat;
        int n0;
        reset   = 1'b1;
        start8  = 1'b0;
        bin8    = '0;
        start16 = 1'b0;
        bin16   = '0;
        tick();
        tick();
        chk("rst_ready8", {31'd0, ready8}, 32'd1);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_bcd8", {20'd0, bcd8}, 32'd0);
        chk("rst_ready16", {31'd0, ready16}, 32'd1);
        reset = 1'b0;
        tick();

        // 1: single conversion of 255, latency 9
        go8(8'd255, 1'b1);
        chk("t1_ready_drop", {31'd0, ready8}, 32'd0);
        wait_done8(lat);
        chk("t1_latency", lat, 9);
        wait_idle8();

        // 2: back-to-back 0 then 99 with start held high
        n0 = ndone8;
        start8 = 1'b1;
        bin8   = 8'd0;
        q8.push_back(ref_bcd(0));
        tick();
        bin8 = 8'd99;
        q8.push_back(ref_bcd(99));
        wait_done8(lat);
        chk("t2_lat0", lat, 9);
        tick();
        start8 = 1'b0;
        chk("t2_reaccept", {31'd0, ready8}, 32'd0);
        wait_idle8();
        chk("t2_ndone", ndone8 - n0, 2);

        // 3: start during SHIFT is ignored
        n0 = ndone8;
        go8(8'd128, 1'b1);
        tick();
        tick();
        start8 = 1'b1;
        bin8   = 8'd7;
        tick();
        start8 = 1'b0;
        wait_idle8();
        repeat (20) tick();
        chk("t3_ndone", ndone8 - n0, 1);
        chk("t3_hold", {20'd0, bcd8}, 32'h128);

        // 4: reset mid-conversion of 200
        n0 = ndone8;
        go8(8'd200, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t4_bcd_clr", {20'd0, bcd8}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t4_ready", {31'd0, ready8}, 32'd1);
        repeat (15) tick();
        chk("t4_no_done", ndone8 - n0, 0);

        // 5: 16-bit instance, 0xFFFF, latency 17
        start16 = 1'b1;
        bin16   = 16'hFFFF;
        q16.push_back(ref_bcd(65535));
        tick();
        start16 = 1'b0;
        chk("t5_ready_drop", {31'd0, ready16}, 32'd0);
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (done16)
                break;
        end
        chk("t5_latency", lat, 17);
        tick();
        chk("t5_bcd", {12'd0, bcd16}, 32'h65535);
        chk("q16_drain", q16.size(), 0);

        // 6: exhaustive sweep of the 8-bit instance
        n0 = ndone8;
        for (int v = 0; v < 256; v++) begin
            go8(8'(v), 1'b1);
            wait_idle8();
        end
        chk("t6_ndone", ndone8 - n0, 256);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
